bpred_btb: RTL and testbench

//   Parametrised branch target buffer with per-entry saturating direction counters.

---
 rtl/bpred_btb.sv | 91 +++++++++
 tb/tb_bpred_btb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with saturating direction counters and resolution statistics.
// Lookup and mispredict are combinational (zero latency); training lands on the next posedge; no backpressure.
module bpred_btb #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_miss
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [CTR_W-1:0]  ctr_q    [DEPTH];
    logic [31:0]       target_q [DEPTH];
    logic [STAT_W-1:0] br_q;
    logic [STAT_W-1:0] miss_q;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = pred_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    // The target only matters for a taken branch; a not-taken one falls through regardless.
    assign mispredict  = upd_valid && !reset &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign stat_br   = br_q;
    assign stat_miss = miss_q;

    // Tag and target arrays are deliberately left out of reset; valid gates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= '0;
            br_q    <= '0;
            miss_q  <= '0;
        end else if (upd_valid) begin
            if (br_q != '1) br_q <= br_q + STAT_W'(1);
            if (mispredict && (miss_q != '1)) miss_q <= miss_q + STAT_W'(1);
            if (upd_hit) begin
                if (upd_is_jump) begin
                    ctr_q[upd_idx]    <= CTR_MAX;
                    target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= upd_is_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end
endmodule

// File: tb/tb_bpred_btb.sv
// Scoreboard bench for bpred_btb: a driver pushes expected outputs from an abstract table model,
// a monitor pops and compares them each cycle; a second instance with 4-bit statistics checks saturation.
module tb_bpred_btb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'h0;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] stat_br, stat_miss;
    logic        s_hit, s_taken, s_mis;
    logic [31:0] s_tgt, s_rdr;
    logic [3:0]  s_br, s_miss;

    always #5 clk = ~clk;

    bpred_btb dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_br(stat_br), .stat_miss(stat_miss)
    );

    bpred_btb #(.STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_tgt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(s_mis), .redirect_pc(s_rdr),
        .stat_br(s_br), .stat_miss(s_miss)
    );

    typedef struct {
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] rdr;
        logic [15:0] br;
        logic [15:0] miss;
        logic [3:0]  br4;
        logic [3:0]  miss4;
    } exp_t;

    exp_t sb[$];
    bit   drv_done = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Abstract model: 16 direct-mapped slots, counter as an integer 0..3, statistics as raw counts.
    bit          m_valid [16];
    int          m_ctr   [16];
    logic [7:0]  m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_br = 0;
    int          m_miss = 0;

    function automatic int midx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == pc[13:6]);
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = $urandom;
        p[13:6] = 8'($urandom_range(0, 3));
        p[5:2]  = 4'($urandom_range(0, 3));
        p[1:0]  = 2'b00;
        if ($urandom_range(0, 3) != 0) p[31:14] = '0;
        return p;
    endfunction

    task automatic step(input bit rst, input logic [31:0] ipc, input bit uv,
                        input logic [31:0] upc, input bit jmp, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        exp_t e;
        int   j;
        @(posedge clk);
        #1;
        reset = rst; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_is_jump = jmp;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;

        e.hit   = mhit(ipc);
        e.tk    = e.hit && (m_ctr[midx(ipc)] >= 2);
        e.tgt   = e.tk ? m_tgt[midx(ipc)] : ipc + 32'd4;
        e.mis   = uv && !rst && ((tk != ptk) || (tk && tgt != ptgt));
        e.rdr   = tk ? tgt : upc + 32'd4;
        e.br    = 16'(sat(m_br, 65535));
        e.miss  = 16'(sat(m_miss, 65535));
        e.br4   = 4'(sat(m_br, 15));
        e.miss4 = 4'(sat(m_miss, 15));
        sb.push_back(e);

        j = midx(upc);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
            m_br = 0; m_miss = 0;
        end else if (uv) begin
            m_br++;
            if (e.mis) m_miss++;
            if (mhit(upc)) begin
                if (jmp) begin m_ctr[j] = 3; m_tgt[j] = tgt; end
                else if (tk) begin m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3; m_tgt[j] = tgt; end
                else m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
            end else if (tk) begin
                m_valid[j] = 1; m_tag[j] = upc[13:6]; m_tgt[j] = tgt;
                m_ctr[j] = jmp ? 3 : 2;
            end
        end
    endtask

    task automatic look(input logic [31:0] ipc);
        step(0, ipc, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] ipc, input logic [31:0] upc, input bit jmp,
                       input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        step(0, ipc, 1, upc, jmp, tk, tgt, ptk, ptgt);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    initial begin : driver
        logic [31:0] pc, tg, ptg;
        bit jm, tk, pt;
        repeat (2) @(posedge clk);

        look(32'h40);
        upd(32'h40, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        look(32'h40);
        upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        look(32'h40);
        repeat (3) upd(32'h40, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        look(32'h40);
        upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        look(32'h40);
        look(32'h80);
        upd(32'h80, 32'h80, 0, 1, 32'h200, 0, 32'h84);
        look(32'h80);
        look(32'h40);
        upd(32'h40, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        look(32'h40);
        upd(32'h40, 32'h40, 1, 1, 32'h180, 0, 32'h44);
        upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 32'h180);
        look(32'h40);
        step(1, 32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 32'h304);
        look(32'h300);
        look(32'hFFFF_FFFC);
        for (int i = 0; i < 20; i++) upd(rpc(), rpc(), 0, 1, 32'h1000 + 32'(i), 0, 32'h0);
        look(32'h40);

        for (int n = 0; n < 800; n++) begin
            pc = rpc();
            jm = ($urandom_range(0, 4) == 0);
            tk = jm ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) < 6);
            tg = 32'h2000 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 9) < 7) begin
                pt  = mhit(pc) && (m_ctr[midx(pc)] >= 2);
                ptg = pt ? m_tgt[midx(pc)] : pc + 32'd4;
            end else begin
                pt  = 1'($urandom);
                ptg = 32'h2000 + 32'($urandom_range(0, 3) * 4);
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : rpc(),
                 ($urandom_range(0, 9) < 7), pc, jm, tk, tg, pt, ptg);
        end
        drv_done = 1;
    end

    initial begin : monitor
        exp_t e;
        int idle = 0;
        while (!(drv_done && sb.size() == 0)) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                idle = 0;
                e = sb.pop_front();
                check("pred_hit", 32'(pred_hit), 32'(e.hit));
                check("pred_taken", 32'(pred_taken), 32'(e.tk));
                check("pred_target", pred_target, e.tgt);
                check("mispredict", 32'(mispredict), 32'(e.mis));
                if (e.mis) check("redirect_pc", redirect_pc, e.rdr);
                check("stat_br", 32'(stat_br), 32'(e.br));
                check("stat_miss", 32'(stat_miss), 32'(e.miss));
                check("stat_br_w4", 32'(s_br), 32'(e.br4));
                check("stat_miss_w4", 32'(s_miss), 32'(e.miss4));
            end else if (++idle > 50) begin
                n_err++;
                $display("FAIL monitor_timeout: got no expected entry for %0d cycles, expected a steady stream", idle);
                break;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
